// File: rtl/sev_seg_decoder.sv
// Snoops a multiplexed active-low seven-segment bus and rebuilds the digit shown at each anode.
// Define SEV_SEG_DEC_HEX_EN to also decode the A..F glyphs as 10..15.
module sev_seg_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    CA,
  input  logic                    CB,
  input  logic                    CC,
  input  logic                    CD,
  input  logic                    CE,
  input  logic                    CF,
  input  logic                    CG,
  input  logic [NUM_DIGITS-1:0]   AN,
  output logic [4*NUM_DIGITS-1:0] DIGITS,
  output logic [NUM_DIGITS-1:0]   DIG_VALID,
  output logic                    UPD,
  output logic [IDX_W-1:0]        UPD_IDX,
  output logic                    ERR
);

  localparam int S_W   = NUM_DIGITS + 7;
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t                  state, next_state;
  logic [CNT_W-1:0]        count, next_count;
  logic [S_W-1:0]          sync_q1, sync_q2, prev_s;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic [NUM_DIGITS-1:0]   an_lit;
  logic                    anode_valid;
  logic                    s_changed;
  logic [IDX_W-1:0]        anode_idx;
  logic                    capture;
  logic [3:0]              dec_val;
  logic                    dec_ok;
  logic                    dec_blank;

  // All-ones reset = no anode selected, all segments dark
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
      prev_s  <= '1;
    end else begin
      sync_q1 <= {AN, CA, CB, CC, CD, CE, CF, CG};
      sync_q2 <= sync_q1;
      prev_s  <= sync_q2;
    end
  end

  assign seg         = sync_q2[6:0];
  assign an          = sync_q2[S_W-1:7];
  assign an_lit      = ~an;
  assign anode_valid = $onehot(an_lit);
  assign s_changed   = (sync_q2 != prev_s);

  always_comb begin
    anode_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (an_lit[i]) anode_idx = IDX_W'(i);
    end
  end

  always_comb begin
    dec_val   = '0;
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    case (seg)
      7'b0000001: dec_val = 4'd0;
      7'b1001111: dec_val = 4'd1;
      7'b0010010: dec_val = 4'd2;
      7'b0000110: dec_val = 4'd3;
      7'b1001100: dec_val = 4'd4;
      7'b0100100: dec_val = 4'd5;
      7'b0100000: dec_val = 4'd6;
      7'b0001111: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0000100: dec_val = 4'd9;
`ifdef SEV_SEG_DEC_HEX_EN
      7'b0001000: dec_val = 4'd10;
      7'b1100000: dec_val = 4'd11;
      7'b0110001: dec_val = 4'd12;
      7'b1000010: dec_val = 4'd13;
      7'b0110000: dec_val = 4'd14;
      7'b0111000: dec_val = 4'd15;
`endif
      7'b1111111: begin
        dec_ok    = 1'b0;
        dec_blank = 1'b1;
      end
      default:    dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= next_state;
      count <= next_count;
    end
  end

  // The counter only advances below CNT_LAST, so it saturates by construction
  always_comb begin
    next_state = state;
    next_count = count;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (anode_valid) begin
          next_state = SETTLE;
          next_count = '0;
        end
      end
      SETTLE: begin
        if (!anode_valid) begin
          next_state = IDLE;
          next_count = '0;
        end else if (s_changed) begin
          next_count = '0;
        end else if (count == CNT_LAST) begin
          capture    = 1'b1;
          next_state = HOLD;
        end else begin
          next_count = count + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!anode_valid) begin
          next_state = IDLE;
          next_count = '0;
        end else if (s_changed) begin
          next_state = SETTLE;
          next_count = '0;
        end
      end
      default: begin
        next_state = IDLE;
        next_count = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DIGITS    <= '0;
      DIG_VALID <= '0;
      UPD       <= 1'b0;
      UPD_IDX   <= '0;
      ERR       <= 1'b0;
    end else begin
      UPD <= 1'b0;
      ERR <= 1'b0;
      if (capture) begin
        if (dec_ok || dec_blank) begin
          UPD     <= 1'b1;
          UPD_IDX <= anode_idx;
        end else begin
          ERR <= 1'b1;
        end
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (anode_idx == IDX_W'(i)) begin
            DIG_VALID[i] <= dec_ok;
            if (dec_ok) DIGITS[4*i +: 4] <= dec_val;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sev_seg_decoder.sv
// Directed and randomized checks of sev_seg_decoder against a run-length reference model.
module tb_sev_seg_decoder;

  localparam int ND = 4;
  localparam int SC = 4;
`ifdef SEV_SEG_DEC_HEX_EN
  localparam int NGLYPH = 16;
`else
  localparam int NGLYPH = 10;
`endif
  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
    7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  localparam logic [6:0] BLANK = 7'b1111111;

  typedef struct packed {
    logic        upd;
    logic        err;
    logic [1:0]  idx;
    logic [15:0] digits;
    logic [3:0]  valid;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ca, cb, cc, cd, ce, cf, cg;
  logic [ND-1:0] an;
  logic [15:0]   digits;
  logic [ND-1:0] dig_valid;
  logic          upd;
  logic [1:0]    upd_idx;
  logic          err;

  int   vectors = 0;
  int   miscompares = 0;
  ev_t  got_q[$];
  ev_t  exp_q[$];
  logic both_hi = 1'b0;

  logic [15:0] m_digits;
  logic [3:0]  m_valid;
  logic [1:0]  m_idx;

  sev_seg_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .CLK(clk), .RST_N(rst_n),
    .CA(ca), .CB(cb), .CC(cc), .CD(cd), .CE(ce), .CF(cf), .CG(cg),
    .AN(an), .DIGITS(digits), .DIG_VALID(dig_valid),
    .UPD(upd), .UPD_IDX(upd_idx), .ERR(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (upd && err) both_hi = 1'b1;
    if (upd || err) got_q.push_back({upd, err, upd_idx, digits, dig_valid});
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ev_t mk_ev(input logic u, input logic e, input logic [1:0] i,
                                input logic [15:0] d, input logic [3:0] v);
    return {u, e, i, d, v};
  endfunction

  task automatic set_in(input logic [3:0] a, input logic [6:0] s);
    an = a;
    {ca, cb, cc, cd, ce, cf, cg} = s;
  endtask

  task automatic idle(input int n);
    set_in(4'b1111, BLANK);
    repeat (n) @(negedge clk);
  endtask

  task automatic compare_events(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_ev%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // Counts rising edges from the first edge after the inputs were driven (edge 0)
  task automatic wait_upd(input string tag, input int exp_edges);
    int k = -1;
    bit seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      k++;
      #1;
      if (upd || err) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, seen ? k : -1, exp_edges);
    @(negedge clk);
  endtask

  // 0..15 glyph value, 16 blank, 17 undecodable
  function automatic int decode_ref(input logic [6:0] p);
    if (p == BLANK) return 16;
    for (int v = 0; v < NGLYPH; v++) if (GLYPH[v] == p) return v;
    return 17;
  endfunction

  // A run of len identical samples with one lit anode is captured once it spans SC+1 edges
  task automatic model_run(input logic [3:0] a, input logic [6:0] s, input int len);
    int idx = 0;
    int d;
    if (len < SC + 1 || $countones(~a) != 1) return;
    for (int i = 0; i < ND; i++) if (!a[i]) idx = i;
    d = decode_ref(s);
    if (d < 16) begin
      m_digits[idx*4 +: 4] = 4'(d);
      m_valid[idx] = 1'b1;
      m_idx = 2'(idx);
      exp_q.push_back(mk_ev(1'b1, 1'b0, m_idx, m_digits, m_valid));
    end else if (d == 16) begin
      m_valid[idx] = 1'b0;
      m_idx = 2'(idx);
      exp_q.push_back(mk_ev(1'b1, 1'b0, m_idx, m_digits, m_valid));
    end else begin
      m_valid[idx] = 1'b0;
      exp_q.push_back(mk_ev(1'b0, 1'b1, m_idx, m_digits, m_valid));
    end
  endtask

  task automatic run(input logic [3:0] a, input logic [6:0] s, input int len);
    set_in(a, s);
    model_run(a, s, len);
    repeat (len) @(negedge clk);
  endtask

  initial begin
    logic [3:0] r_an, prev_an;
    logic [6:0] r_seg, prev_seg;
    int c, len;

    // reset held with random activity on the bus
    set_in(4'b1111, BLANK);
    for (int i = 0; i < 5; i++) begin
      set_in(4'($urandom), 7'($urandom));
      @(negedge clk);
      chk($sformatf("rst_digits%0d", i), digits, 16'h0);
      chk($sformatf("rst_valid%0d", i), dig_valid, 4'h0);
    end
    chk("rst_idx", upd_idx, 2'd0);
    compare_events("rst");
    idle(1);
    rst_n = 1'b1;
    idle(5);

    // single capture and its latency
    set_in(4'b1110, 7'b0000110);
    wait_upd("single_latency", 6);
    repeat (13) @(negedge clk);
    idle(8);
    exp_q.push_back(mk_ev(1'b1, 1'b0, 2'd0, 16'h0003, 4'b0001));
    compare_events("single");
    chk("single_digit0", digits[3:0], 4'd3);
    chk("single_valid", dig_valid, 4'b0001);

    // scan across all four anodes
    set_in(4'b1110, GLYPH[1]); repeat (8) @(negedge clk);
    set_in(4'b1101, GLYPH[2]); repeat (8) @(negedge clk);
    set_in(4'b1011, GLYPH[3]); repeat (8) @(negedge clk);
    set_in(4'b0111, GLYPH[4]); repeat (8) @(negedge clk);
    idle(8);
    exp_q.push_back(mk_ev(1'b1, 1'b0, 2'd0, 16'h0001, 4'b0001));
    exp_q.push_back(mk_ev(1'b1, 1'b0, 2'd1, 16'h0021, 4'b0011));
    exp_q.push_back(mk_ev(1'b1, 1'b0, 2'd2, 16'h0321, 4'b0111));
    exp_q.push_back(mk_ev(1'b1, 1'b0, 2'd3, 16'h4321, 4'b1111));
    compare_events("scan");
    chk("scan_digits", digits, 16'h4321);
    chk("scan_valid", dig_valid, 4'b1111);

    // two-cycle glitch to 9 inside a stable 8
    set_in(4'b1101, GLYPH[8]); repeat (10) @(negedge clk);
    set_in(4'b1101, GLYPH[9]); repeat (2) @(negedge clk);
    set_in(4'b1101, GLYPH[8]); repeat (10) @(negedge clk);
    idle(8);
    exp_q.push_back(mk_ev(1'b1, 1'b0, 2'd1, 16'h4381, 4'b1111));
    exp_q.push_back(mk_ev(1'b1, 1'b0, 2'd1, 16'h4381, 4'b1111));
    compare_events("glitch");
    chk("glitch_digit1", digits[7:4], 4'd8);

    // 'A' glyph on anode 2
    set_in(4'b1011, 7'b0001000); repeat (10) @(negedge clk);
    idle(8);
`ifdef SEV_SEG_DEC_HEX_EN
    exp_q.push_back(mk_ev(1'b1, 1'b0, 2'd2, 16'h4A81, 4'b1111));
    compare_events("hex");
    chk("hex_digit2", digits[11:8], 4'hA);
    chk("hex_valid2", dig_valid[2], 1'b1);
`else
    exp_q.push_back(mk_ev(1'b0, 1'b1, 2'd1, 16'h4381, 4'b1011));
    compare_events("err");
    chk("err_digit2", digits[11:8], 4'h3);
    chk("err_valid2", dig_valid[2], 1'b0);
`endif

    // two anodes lit at once is never captured
    set_in(4'b1100, GLYPH[8]); repeat (20) @(negedge clk);
    idle(4);
    compare_events("two_anodes");

    // reset in the middle of settling on anode 3
    set_in(4'b0111, GLYPH[5]);
    repeat (4) @(negedge clk);
    compare_events("midrst_pre");
    rst_n = 1'b0;
    #1;
    chk("midrst_digits", digits, 16'h0);
    chk("midrst_valid", dig_valid, 4'h0);
    chk("midrst_idx", upd_idx, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_upd("midrst_latency", 6);
    repeat (3) @(negedge clk);
    idle(8);
    exp_q.push_back(mk_ev(1'b1, 1'b0, 2'd3, 16'h5000, 4'b1000));
    compare_events("midrst");

    // randomized runs against the reference model
    idle(2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    got_q.delete();
    m_digits = '0;
    m_valid  = '0;
    m_idx    = '0;
    prev_an  = 4'b1111;
    prev_seg = BLANK;
    for (int r = 0; r < 80; r++) begin
      do begin
        if ($urandom_range(0, 9) < 8) begin
          r_an = ~(4'b0001 << $urandom_range(0, 3));
        end else begin
          do r_an = 4'($urandom); while ($countones(~r_an) == 1);
        end
        c = $urandom_range(0, 9);
        if (c < 6)      r_seg = GLYPH[$urandom_range(0, 15)];
        else if (c < 7) r_seg = BLANK;
        else            r_seg = 7'($urandom);
      end while (r_an == prev_an && r_seg == prev_seg);
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, SC - 1) : $urandom_range(SC + 2, SC + 6);
      run(r_an, r_seg, len);
      prev_an  = r_an;
      prev_seg = r_seg;
    end
    idle(12);
    compare_events("rand");
    chk("rand_digits", digits, m_digits);
    chk("rand_valid", dig_valid, m_valid);
    chk("rand_idx", upd_idx, m_idx);
    chk("upd_err_exclusive", both_hi, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
